// File: rtl/m_clk_gate_ctrl_if.sv
// Activity/enable bundle between a gated sub-domain and its clock-gate controller.
// The controller side uses the slave modport.
interface m_clk_gate_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             req;
  logic             busy;
  logic             force_on;
  logic             gate_en;
  logic             ack;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] wake_cnt;

  modport master (
    output req, busy, force_on,
    input  gate_en, ack, state_o, wake_cnt
  );

  modport slave (
    input  req, busy, force_on,
    output gate_en, ack, state_o, wake_cnt
  );
endinterface

// File: rtl/m_clk_gate_ctrl.sv
// Sequential enable controller for a gated clock branch: wake settle delay,
// idle hysteresis timeout and a wake-event counter, all outputs from flops.
module m_clk_gate_ctrl #(
  parameter int WAKE_CYCLES = 2,
  parameter int IDLE_CYCLES = 16,
  parameter int CNT_W       = 16
) (
  input logic              clk,
  input logic              rst,
  m_clk_gate_ctrl_if.slave bus
);

  localparam int MAX_CYC = (WAKE_CYCLES > IDLE_CYCLES) ? WAKE_CYCLES : IDLE_CYCLES;
  localparam int TMR_W   = $clog2(MAX_CYC) + 1;
  localparam logic [TMR_W-1:0] WAKE_LAST = TMR_W'(WAKE_CYCLES - 1);
  localparam logic [TMR_W-1:0] IDLE_LAST = TMR_W'(IDLE_CYCLES - 1);

  if (WAKE_CYCLES < 1 || IDLE_CYCLES < 1) begin : g_param_err
    $error("m_clk_gate_ctrl: WAKE_CYCLES and IDLE_CYCLES must both be >= 1");
  end

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_WAKE  = 2'd1,
    ST_ON    = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t           r_state;
  logic [TMR_W-1:0] r_tmr;
  logic             r_gate_en;
  logic             r_ack;
  logic [CNT_W-1:0] r_wake_cnt;
  logic             w_act;

  assign w_act = bus.req | bus.busy | bus.force_on;

  // gate_en/ack are registered together with the next state so they never glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_OFF;
      r_tmr      <= '0;
      r_gate_en  <= 1'b0;
      r_ack      <= 1'b0;
      r_wake_cnt <= '0;
    end else begin
      case (r_state)
        ST_OFF: begin
          if (w_act) begin
            r_state    <= ST_WAKE;
            r_tmr      <= '0;
            r_gate_en  <= 1'b1;
            r_ack      <= 1'b0;
            r_wake_cnt <= r_wake_cnt + CNT_W'(1);
          end
        end
        // A wake always completes, whatever the inputs do meanwhile.
        ST_WAKE: begin
          if (r_tmr == WAKE_LAST) begin
            r_state <= ST_ON;
            r_tmr   <= '0;
            r_ack   <= 1'b1;
          end else begin
            r_tmr <= r_tmr + TMR_W'(1);
          end
        end
        ST_ON: begin
          if (!w_act) begin
            r_state <= ST_DRAIN;
            r_tmr   <= '0;
          end
        end
        // Reactivation is checked first so it beats a coincident timeout.
        ST_DRAIN: begin
          if (w_act) begin
            r_state <= ST_ON;
            r_tmr   <= '0;
          end else if (r_tmr == IDLE_LAST) begin
            r_state   <= ST_OFF;
            r_tmr     <= '0;
            r_gate_en <= 1'b0;
            r_ack     <= 1'b0;
          end else begin
            r_tmr <= r_tmr + TMR_W'(1);
          end
        end
        default: begin
          r_state   <= ST_OFF;
          r_tmr     <= '0;
          r_gate_en <= 1'b0;
          r_ack     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gate_en  = r_gate_en;
  assign bus.ack      = r_ack;
  assign bus.state_o  = r_state;
  assign bus.wake_cnt = r_wake_cnt;

endmodule

// File: tb/tb_m_clk_gate_ctrl.sv
// Self-checking bench for m_clk_gate_ctrl: vector table plus timed sequences,
// with expected outputs queued at drive time and compared after each edge.
module tb_m_clk_gate_ctrl;

  localparam int WAKE  = 2;
  localparam int IDLE  = 16;
  localparam int WAKE2 = 1;
  localparam int IDLE2 = 3;

  localparam logic [1:0] S_OFF   = 2'd0;
  localparam logic [1:0] S_WAKE  = 2'd1;
  localparam logic [1:0] S_ON    = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic clk = 1'b0;
  logic rst;
  logic req;
  logic busy;
  logic forceOn;

  int checkCount = 0;
  int errorCount = 0;

  typedef struct {
    logic       rst;
    logic       req;
    logic       busy;
    logic       forceOn;
    logic [1:0] expState;
    logic       expGate;
    logic       expAck;
    logic [15:0] expCnt;
  } vec_t;

  typedef struct {
    bit          sel;
    logic [1:0]  state;
    logic        gate;
    logic        ack;
    logic [15:0] cnt;
    string       name;
  } exp_t;

  exp_t expQ[$];
  vec_t vecs[20];

  m_clk_gate_ctrl_if #(.CNT_W(16)) bus1();
  m_clk_gate_ctrl_if #(.CNT_W(2))  bus2();

  assign bus1.req      = req;
  assign bus1.busy     = busy;
  assign bus1.force_on = forceOn;
  assign bus2.req      = req;
  assign bus2.busy     = busy;
  assign bus2.force_on = forceOn;

  m_clk_gate_ctrl #(.WAKE_CYCLES(WAKE), .IDLE_CYCLES(IDLE), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  m_clk_gate_ctrl #(.WAKE_CYCLES(WAKE2), .IDLE_CYCLES(IDLE2), .CNT_W(2)) dutSmall (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic compareField(input string nm, input string field,
                              input logic [15:0] act, input logic [15:0] expv);
    checkCount++;
    if (act !== expv) begin
      errorCount++;
      $display("[TB] FAIL %s.%s: got %0h expected %0h", nm, field, act, expv);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    logic [1:0]  obsState;
    logic        obsGate;
    logic        obsAck;
    logic [15:0] obsCnt;
    if (expQ.size() == 0) begin
      checkCount++;
      errorCount++;
      $display("[TB] FAIL scoreboard: got empty queue expected an entry");
      return;
    end
    e = expQ.pop_front();
    if (e.sel) begin
      obsState = bus2.state_o;
      obsGate  = bus2.gate_en;
      obsAck   = bus2.ack;
      obsCnt   = {14'd0, bus2.wake_cnt};
    end else begin
      obsState = bus1.state_o;
      obsGate  = bus1.gate_en;
      obsAck   = bus1.ack;
      obsCnt   = bus1.wake_cnt;
    end
    compareField(e.name, "state",   {14'd0, obsState}, {14'd0, e.state});
    compareField(e.name, "gate_en", {15'd0, obsGate},  {15'd0, e.gate});
    compareField(e.name, "ack",     {15'd0, obsAck},   {15'd0, e.ack});
    compareField(e.name, "wake_cnt", obsCnt, e.cnt);
  endtask

  task automatic applyStimulus(input bit sel, input logic r, input logic q,
                               input logic b, input logic f,
                               input logic [1:0] st, input logic g, input logic a,
                               input logic [15:0] c, input string nm);
    exp_t e;
    rst     = r;
    req     = q;
    busy    = b;
    forceOn = f;
    e.sel   = sel;
    e.state = st;
    e.gate  = g;
    e.ack   = a;
    e.cnt   = c;
    e.name  = nm;
    expQ.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  // Expected main-DUT state k edges after a wake, for a wake request at k=0
  // and the idle stretch starting at drainK.
  function automatic logic [1:0] seqState(input int k, input int drainK, input int idle);
    if (k < WAKE)               return S_WAKE;
    if (k < drainK)             return S_ON;
    if (k < drainK + idle)      return S_DRAIN;
    return S_OFF;
  endfunction

  initial begin
    logic [1:0] st;
    rst     = 1'b1;
    req     = 1'b0;
    busy    = 1'b0;
    forceOn = 1'b0;

    //          rst   req   busy  force  state    gate  ack   cnt
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, S_OFF,   1'b0, 1'b0, 16'd0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, S_OFF,   1'b0, 1'b0, 16'd0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, S_OFF,   1'b0, 1'b0, 16'd0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, S_WAKE,  1'b1, 1'b0, 16'd1};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, S_WAKE,  1'b1, 1'b0, 16'd1};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, S_ON,    1'b1, 1'b1, 16'd1};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, S_ON,    1'b1, 1'b1, 16'd1};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, S_ON,    1'b1, 1'b1, 16'd1};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, S_DRAIN, 1'b1, 1'b1, 16'd1};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, S_DRAIN, 1'b1, 1'b1, 16'd1};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, S_ON,    1'b1, 1'b1, 16'd1};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, S_DRAIN, 1'b1, 1'b1, 16'd1};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, S_OFF,   1'b0, 1'b0, 16'd0};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, S_WAKE,  1'b1, 1'b0, 16'd1};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, S_OFF,   1'b0, 1'b0, 16'd0};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b0, S_WAKE,  1'b1, 1'b0, 16'd1};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, S_WAKE,  1'b1, 1'b0, 16'd1};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b0, S_ON,    1'b1, 1'b1, 16'd1};
    vecs[18] = '{1'b1, 1'b0, 1'b0, 1'b1, S_OFF,   1'b0, 1'b0, 16'd0};
    vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b0, S_OFF,   1'b0, 1'b0, 16'd0};

    @(posedge clk);
    #1;
    $display("[TB] vector table");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, vecs[i].rst, vecs[i].req, vecs[i].busy, vecs[i].forceOn,
                    vecs[i].expState, vecs[i].expGate, vecs[i].expAck, vecs[i].expCnt,
                    $sformatf("vec%0d", i));
    end

    $display("[TB] single req pulse wake/sleep");
    for (int k = 0; k <= WAKE + 1 + IDLE + 1; k++) begin
      st = seqState(k, WAKE + 1, IDLE);
      applyStimulus(1'b0, 1'b0, (k == 0), 1'b0, 1'b0, st, (st != S_OFF),
                    (st == S_ON || st == S_DRAIN), 16'd1, $sformatf("pulse_k%0d", k));
    end

    $display("[TB] reactivation at last idle cycle");
    for (int k = 0; k <= 2 * (WAKE + 1 + IDLE) + 1; k++) begin
      if (k == WAKE + 1 + IDLE)
        st = S_ON;
      else if (k < WAKE + 1 + IDLE)
        st = seqState(k, WAKE + 1, IDLE);
      else
        st = (k < WAKE + 2 + 2 * IDLE) ? S_DRAIN : S_OFF;
      applyStimulus(1'b0, 1'b0, (k == 0), (k == WAKE + 1 + IDLE), 1'b0, st,
                    (st != S_OFF), (st == S_ON || st == S_DRAIN), 16'd2,
                    $sformatf("react_k%0d", k));
    end

    $display("[TB] force_on hold and release");
    for (int k = 0; k < 100 + IDLE + 2; k++) begin
      st = seqState(k, 100, IDLE);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, (k < 100), st, (st != S_OFF),
                    (st == S_ON || st == S_DRAIN), 16'd3, $sformatf("force_k%0d", k));
    end

    $display("[TB] narrow counter wrap");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, S_OFF, 1'b0, 1'b0, 16'd0, "wrap_rst");
    for (int cyc = 1; cyc <= 5; cyc++) begin
      for (int k = 0; k <= WAKE2 + 1 + IDLE2; k++) begin
        if (k < WAKE2)                  st = S_WAKE;
        else if (k == WAKE2)            st = S_ON;
        else if (k < WAKE2 + 1 + IDLE2) st = S_DRAIN;
        else                            st = S_OFF;
        applyStimulus(1'b1, 1'b0, (k == 0), 1'b0, 1'b0, st, (st != S_OFF),
                      (st == S_ON || st == S_DRAIN), 16'(cyc % 4),
                      $sformatf("wrap_c%0d_k%0d", cyc, k));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
